// File: rtl/posit_to_fixed_if.sv
// Handshake and result bundle between a posit producer and the posit-to-fixed decoder.
// The master side issues start/in; the slave side returns the fixed-point result and flags.
interface posit_to_fixed_if #(
  parameter int N = 16,
  parameter int W = 32
);
  logic         start_i;
  logic [N-1:0] in_i;
  logic [W-1:0] out_o;
  logic         inf_o;
  logic         zero_o;
  logic         sat_o;
  logic         udf_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output start_i, in_i,
    input  out_o, inf_o, zero_o, sat_o, udf_o, busy_o, done_o
  );

  modport slave (
    input  start_i, in_i,
    output out_o, inf_o, zero_o, sat_o, udf_o, busy_o, done_o
  );
endinterface

// File: rtl/posit_to_fixed.sv
// Sequential posit<N,es> to signed fixed-point (FRAC fractional bits) decoder.
// The regime is found by scanning one bit per clock; a single conversion cycle then
// extracts exponent and fraction and barrel-shifts the significand into place.
module posit_to_fixed #(
  parameter int N    = 16,
  parameter int es   = 3,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input logic             clk,
  input logic             rst,
  posit_to_fixed_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;
  localparam int SW = 10;
  localparam int FW = N - 1 + es;

  localparam logic [N-1:0]          NAR_WORD   = {1'b1, {(N-1){1'b0}}};
  localparam logic [W-1:0]          NAR_OUT    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]          SAT_MAG    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0]  SAT_SCALE  = SW'(W - 1 - FRAC);
  localparam logic signed [SW-1:0]  UDF_SCALE  = SW'(-FRAC);
  localparam logic signed [SW-1:0]  SHIFT_BASE = SW'(W - FRAC + N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, CONV, DONE} stateT;

  stateT state_q, state_d;

  logic [N-1:0]  word_q, word_d;
  logic          sign_q, sign_d;
  logic          r0_q, r0_d;
  logic          term_q, term_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] runLen_q, runLen_d;
  logic [W-1:0]  out_q, out_d;
  logic          inf_q, inf_d;
  logic          zero_q, zero_d;
  logic          sat_q, sat_d;
  logic          udf_q, udf_d;

  logic [N-1:0]         absIn;
  logic [CW-1:0]        consumed;
  logic [FW-1:0]        fieldBits;
  logic [es-1:0]        expo;
  logic [N-1:0]         sig;
  logic signed [SW-1:0] runExt;
  logic signed [SW-1:0] kVal;
  logic signed [SW-1:0] scale;
  logic signed [SW-1:0] shiftAmt;
  logic [N+W-1:0]       wide;
  logic                 ovf;
  logic                 unf;
  logic [W-1:0]         mag;

  // Conversion datapath: strip the regime, pick exponent/fraction, and shift 1.f into the Q format
  always_comb begin
    consumed  = term_q ? ({1'b0, runLen_q} + CW'(1)) : CW'(N - 1);
    fieldBits = {word_q[N-2:0], {es{1'b0}}} << consumed;
    expo      = fieldBits[FW-1 -: es];
    sig       = {1'b1, fieldBits[N-2:0]};
    runExt    = SW'(runLen_q);
    kVal      = r0_q ? (runExt - SW'(1)) : -runExt;
    scale     = (kVal <<< es) + SW'(expo);
    shiftAmt  = SHIFT_BASE - scale;
    wide      = {sig, {W{1'b0}}} >> shiftAmt;
    unf       = (scale < UDF_SCALE);
    ovf       = (scale >= SAT_SCALE) || (|wide[N+W-1:W-1]);
    mag       = ovf ? SAT_MAG : (unf ? '0 : wide[W-1:0]);
  end

  // Next-state and register-update logic for the IDLE/SCAN/CONV/DONE sequence
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    sign_d   = sign_q;
    r0_d     = r0_q;
    term_d   = term_q;
    idx_d    = idx_q;
    runLen_d = runLen_q;
    out_d    = out_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    sat_d    = sat_q;
    udf_d    = udf_q;
    absIn    = bus.in_i[N-1] ? -bus.in_i : bus.in_i;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          inf_d  = 1'b0;
          zero_d = 1'b0;
          sat_d  = 1'b0;
          udf_d  = 1'b0;
          if (bus.in_i == '0) begin
            zero_d  = 1'b1;
            out_d   = '0;
            state_d = DONE;
          end else if (bus.in_i == NAR_WORD) begin
            inf_d   = 1'b1;
            out_d   = NAR_OUT;
            state_d = DONE;
          end else begin
            sign_d   = bus.in_i[N-1];
            word_d   = absIn;
            r0_d     = absIn[N-2];
            term_d   = 1'b0;
            idx_d    = IW'(N - 2);
            runLen_d = '0;
            state_d  = SCAN;
          end
        end
      end
      SCAN: begin
        if (word_q[idx_q] == r0_q) begin
          runLen_d = runLen_q + IW'(1);
          if (idx_q == '0) begin
            state_d = CONV;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end else begin
          term_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        sat_d   = ovf;
        udf_d   = unf;
        out_d   = sign_q ? -mag : mag;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, scan bookkeeping and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      sign_q   <= 1'b0;
      r0_q     <= 1'b0;
      term_q   <= 1'b0;
      idx_q    <= '0;
      runLen_q <= '0;
      out_q    <= '0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      sat_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      word_q   <= word_d;
      sign_q   <= sign_d;
      r0_q     <= r0_d;
      term_q   <= term_d;
      idx_q    <= idx_d;
      runLen_q <= runLen_d;
      out_q    <= out_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      sat_q    <= sat_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.out_o  = out_q;
  assign bus.inf_o  = inf_q;
  assign bus.zero_o = zero_q;
  assign bus.sat_o  = sat_q;
  assign bus.udf_o  = udf_q;
  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = (state_q == DONE);

endmodule

// File: tb/tb_posit_to_fixed.sv
// Randomized scoreboard bench for posit_to_fixed: stimulus pushes expected results from a
// real-arithmetic posit model; an independent monitor pops and compares on every done pulse.
module tb_posit_to_fixed;

  typedef struct {
    logic [31:0] out;
    logic        inf;
    logic        zero;
    logic        sat;
    logic        udf;
    int          lat;
    int          startCyc;
  } expT;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   pushCnt;
  int   doneCnt;
  expT  expQ[$];

  posit_to_fixed_if #(.N(16), .W(32)) bus ();

  posit_to_fixed dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure start-to-done latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Posit decode from first principles: regime run, exponent, fraction, value in real arithmetic
  function automatic expT refModel(input logic [15:0] p);
    expT         r;
    logic [15:0] a;
    logic        r0;
    logic        neg;
    int          m;
    int          pos;
    int          k;
    int          e;
    int          nf;
    int          fv;
    int          scale;
    real         v;
    logic [31:0] magv;
    r.out = '0; r.inf = 1'b0; r.zero = 1'b0; r.sat = 1'b0; r.udf = 1'b0;
    r.lat = 0; r.startCyc = 0;
    if (p == 16'h0000) begin
      r.zero = 1'b1; r.lat = 1;
      return r;
    end
    if (p == 16'h8000) begin
      r.inf = 1'b1; r.out = 32'h8000_0000; r.lat = 1;
      return r;
    end
    neg = p[15];
    a   = neg ? (~p + 16'd1) : p;
    r0  = a[14];
    m   = 0;
    pos = 14;
    while (pos >= 0 && a[pos] == r0) begin
      m++;
      pos--;
    end
    if (pos >= 0) begin
      r.lat = m + 3;
      pos--;
    end else begin
      r.lat = 17;
    end
    k = r0 ? m - 1 : -m;
    e = 0;
    for (int j = 0; j < 3; j++) begin
      e = e * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
      pos--;
    end
    nf    = (pos >= 0) ? pos + 1 : 0;
    fv    = int'(a) % (1 << nf);
    scale = k * 8 + e;
    if (scale < -16) begin
      r.udf = 1'b1;
      r.out = '0;
    end else begin
      v = (1.0 + real'(fv) / (2.0 ** nf)) * (2.0 ** (scale + 16));
      if (v >= 2.0 ** 31) begin
        r.sat = 1'b1;
        magv  = 32'h7FFF_FFFF;
      end else begin
        magv = 32'(longint'($floor(v)));
      end
      r.out = neg ? -magv : magv;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input logic [15:0] val);
    expT e;
    e          = refModel(val);
    e.startCyc = cyc;
    expQ.push_back(e);
    pushCnt++;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (bus.busy_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("idle_timeout", 32'(guard), 32'd0);
  endtask

  // Single request: one-cycle start pulse, expected result queued at issue time
  task automatic applyStimulus(input logic [15:0] val);
    waitIdle();
    bus.start_i = 1'b1;
    bus.in_i    = val;
    pushExpected(val);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.in_i    = 16'($urandom);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      expT e;
      doneCnt++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out", bus.out_o, e.out);
        checkOutput("flags", {28'd0, bus.inf_o, bus.zero_o, bus.sat_o, bus.udf_o},
                    {28'd0, e.inf, e.zero, e.sat, e.udf});
        checkOutput("latency", 32'(cyc - e.startCyc), 32'(e.lat));
      end
    end
  end

  logic [15:0] directed [15];
  initial begin
    directed = '{16'h4000, 16'h4200, 16'h4400, 16'h3C00, 16'hC000, 16'h6000, 16'h0000,
                 16'h8000, 16'h7700, 16'h7FFF, 16'h0001, 16'h8001, 16'hFFFF, 16'h8900,
                 16'h0100};
  end

  // Main sequence: reset, directed values, held-start, mid-scan reset, random sweep, drain
  initial begin
    int guard;
    cyc = 0; checks = 0; errors = 0; pushCnt = 0; doneCnt = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.in_i    = 16'h0000;
    repeat (2) @(negedge clk);
    checkOutput("reset_state",
                {bus.out_o[31:6] | 26'd0, bus.inf_o, bus.zero_o, bus.sat_o, bus.udf_o,
                 bus.busy_o, bus.done_o} | {26'd0, 6'd0} | {26'd0, 6'd0} |
                {{26{1'b0}}, 6'd0} | 32'(bus.out_o[5:0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) applyStimulus(directed[i]);

    // start held high: in changes during busy, a new request is taken only back in IDLE
    waitIdle();
    bus.start_i = 1'b1;
    bus.in_i    = 16'h4200;
    pushExpected(16'h4200);
    @(negedge clk);
    guard = 0;
    while (!bus.done_o && guard < 50) begin
      bus.in_i = 16'($urandom);
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("held_timeout", 32'(guard), 32'd0);
    bus.in_i = 16'h6000;
    @(negedge clk);
    pushExpected(16'h6000);
    @(negedge clk);
    bus.start_i = 1'b0;
    waitIdle();

    // reset during the regime scan of 0x7FFF aborts it without a done
    bus.start_i = 1'b1;
    bus.in_i    = 16'h7FFF;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_out", bus.out_o, 32'd0);
    checkOutput("abort_ctrl", {26'd0, bus.inf_o, bus.zero_o, bus.sat_o, bus.udf_o,
                bus.busy_o, bus.done_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(16'h4000);

    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) applyStimulus(16'h8000);
      else applyStimulus(16'($urandom_range(0, 65535)));
    end

    guard = 0;
    while (expQ.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    checkOutput("done_count", 32'(doneCnt), 32'(pushCnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
